// File: rtl/mul_sequencer_if.sv
// Purpose: bundles the execute-stage request/HI-LO bus and the multiplier link of mul_sequencer.
// Latency: wires only; no state.
// Backpressure: the sequencer drives stall/busy; the requester holds go/write/read until stall drops.
// Ports (modport slave = sequencer side):
//   in : go, is_signed, a, b, write_hi, write_lo, wdata, read_hi, read_lo, mul_product
//   out: hi, lo, busy, stall, mul_a, mul_b, mul_st
// The master side is the execute stage together with the multiplier, which returns mul_product.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic               go;
  logic               is_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               write_hi;
  logic               write_lo;
  logic [WIDTH-1:0]   wdata;
  logic               read_hi;
  logic               read_lo;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;
  logic               stall;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_st;
  logic [2*WIDTH-1:0] mul_product;

  modport master (
    output go, is_signed, a, b, write_hi, write_lo, wdata, read_hi, read_lo, mul_product,
    input  hi, lo, busy, stall, mul_a, mul_b, mul_st
  );

  modport slave (
    input  go, is_signed, a, b, write_hi, write_lo, wdata, read_hi, read_lo, mul_product,
    output hi, lo, busy, stall, mul_a, mul_b, mul_st
  );
endinterface

// File: rtl/mul_sequencer.sv
// Purpose: MULT/MULTU sequencer around an unsigned multiplier; owns HI/LO and MTHI/MTLO writes.
// Latency: go accepted in cycle 0, new HI/LO visible and busy low from cycle LATENCY+3.
// Backpressure: no queue; stall = busy & any HI/LO request, and the requester holds until busy falls.
// Ports: clk, reset (synchronous, active-high), bus (mul_sequencer_if.slave).
module mul_sequencer #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 33
) (
  input  logic           clk,
  input  logic           reset,
  mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FIX} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0] mul_b_q;
  logic [PW-1:0]    product_fixed;

  // Magnitude of a signed operand; the most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn & v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  always_comb begin
    state_nxt  = state;
    bus.busy   = 1'b1;
    bus.mul_st = 1'b0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.go) state_nxt = S_START;
      end
      S_START: begin
        bus.mul_st = 1'b1;
        state_nxt  = S_WAIT;
      end
      // cnt runs 0..LATENCY-1, so WAIT lasts exactly LATENCY cycles.
      S_WAIT:  if (cnt == CW'(LATENCY - 1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.stall = bus.busy &
                     (bus.go | bus.write_hi | bus.write_lo | bus.read_hi | bus.read_lo);

  // Two's-complement negate of the full-width unsigned product when the signs differed.
  assign product_fixed = neg ? (~bus.mul_product + PW'(1)) : bus.mul_product;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      neg     <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          // go has priority over MTHI/MTLO in the same cycle.
          if (bus.go) begin
            mul_a_q <= magnitude(bus.a, bus.is_signed);
            mul_b_q <= magnitude(bus.b, bus.is_signed);
            neg     <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            cnt     <= '0;
          end else begin
            if (bus.write_hi) hi_q <= bus.wdata;
            if (bus.write_lo) lo_q <= bus.wdata;
          end
        end
        S_WAIT:  cnt <= cnt + CW'(1);
        S_FIX:   {hi_q, lo_q} <= product_fixed;
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// Purpose: self-checking bench for mul_sequencer with a fixed-latency multiplier model.
// Latency: checks the LATENCY+3 cycle go-to-result timing for every vector.
// Backpressure: exercises stall/hold, busy-time write suppression and mid-operation reset.
module tb_mul_sequencer;
  localparam int WIDTH   = 32;
  localparam int LATENCY = 33;
  localparam int PW      = 2 * WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  mul_sequencer #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier model: captures the operands on mul_st and presents the product only
  // LATENCY cycles after the start pulse; garbage before that.
  logic [PW-1:0] m_prod;
  int            m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (bus.mul_st) begin
      m_prod <= PW'(bus.mul_a) * PW'(bus.mul_b);
      m_cnt  <= 1;
    end else if (m_cnt != 0 && m_cnt < LATENCY) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign bus.mul_product = (m_cnt >= LATENCY) ? m_prod : 64'hA5A5_5A5A_C3C3_3C3C;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  // go in cycle 0; checks START in cycle 1, busy through cycle 35, result in cycle 36.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ma, input logic [31:0] mb,
                        input logic [31:0] hi, input logic [31:0] lo);
    int pulses;
    @(negedge clk);
    bus.go = 1'b1; bus.is_signed = sgn; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.go = 1'b0; bus.a = '0; bus.b = '0;
    check({tag, " busy_c1"}, 64'(bus.busy), 64'd1);
    check({tag, " mul_st_c1"}, 64'(bus.mul_st), 64'd1);
    check({tag, " mul_a"}, 64'(bus.mul_a), 64'(ma));
    check({tag, " mul_b"}, 64'(bus.mul_b), 64'(mb));
    pulses = 0;
    for (int c = 2; c <= LATENCY + 2; c++) begin
      @(negedge clk);
      if (bus.mul_st) pulses++;
    end
    check({tag, " extra_mul_st"}, 64'(pulses), 64'd0);
    check({tag, " busy_c35"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    check({tag, " busy_c36"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi), 64'(hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(lo));
  endtask

  task automatic idle_inputs();
    bus.go = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    bus.write_hi = 1'b0; bus.write_lo = 1'b0; bus.wdata = '0;
    bus.read_hi = 1'b0; bus.read_lo = 1'b0;
  endtask

  initial begin
    int          bad_stall;
    int          bad_lo;
    logic [31:0] old_lo;

    //          sgn   a             b             mul_a         mul_b         hi            lo
    vecs[0] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'h00000003, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[4] = '{1'b0, 32'h00000007, 32'h00000006, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
    vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001};
    vecs[6] = '{1'b0, 32'h80000000, 32'h00000002, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[7] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000007, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFF2};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset mul_st", 64'(bus.mul_st), 64'd0);
    check("reset mul_a", 64'(bus.mul_a), 64'd0);
    bus.read_hi = 1'b1;
    #1;
    check("idle read no stall", 64'(bus.stall), 64'd0);
    bus.read_hi = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].ma, vecs[i].mb, vecs[i].hi, vecs[i].lo);

    // Stall and hold: -3*5 in flight, second go held from cycle 3, read_lo from cycle 5.
    old_lo = vecs[7].lo;
    @(negedge clk);
    bus.go = 1'b1; bus.is_signed = 1'b1; bus.a = 32'hFFFFFFFD; bus.b = 32'h5;
    @(negedge clk);
    bus.go = 1'b0;
    @(negedge clk);
    bad_stall = 0;
    bad_lo    = 0;
    for (int c = 3; c <= LATENCY + 2; c++) begin
      @(negedge clk);
      if (c == 3) begin
        bus.go = 1'b1; bus.is_signed = 1'b0; bus.a = 32'h7; bus.b = 32'h6;
      end
      if (c >= 5) bus.read_lo = 1'b1;
      #1;
      if (bus.stall !== 1'b1) bad_stall++;
      if (bus.lo !== old_lo) bad_lo++;
    end
    check("hold stall cycles", 64'(bad_stall), 64'd0);
    check("hold lo unchanged", 64'(bad_lo), 64'd0);
    @(negedge clk);
    #1;
    check("hold busy_c36", 64'(bus.busy), 64'd0);
    check("hold stall_c36", 64'(bus.stall), 64'd0);
    check("hold lo_c36", 64'(bus.lo), 64'hFFFFFFF1);
    check("hold hi_c36", 64'(bus.hi), 64'hFFFFFFFF);
    @(negedge clk);
    check("held go mul_st_c37", 64'(bus.mul_st), 64'd1);
    check("held go mul_a", 64'(bus.mul_a), 64'd7);
    check("held go mul_b", 64'(bus.mul_b), 64'd6);
    idle_inputs();
    repeat (LATENCY + 2) @(negedge clk);
    check("held go lo", 64'(bus.lo), 64'h2A);
    check("held go hi", 64'(bus.hi), 64'h0);

    // MTHI / MTLO in IDLE, singly and together.
    @(negedge clk);
    bus.write_hi = 1'b1; bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.write_hi = 1'b0;
    check("mthi hi", 64'(bus.hi), 64'h12345678);
    check("mthi lo kept", 64'(bus.lo), 64'h2A);
    bus.write_hi = 1'b1; bus.write_lo = 1'b1; bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.write_hi = 1'b0; bus.write_lo = 1'b0;
    check("mthi+mtlo hi", 64'(bus.hi), 64'hCAFEF00D);
    check("mthi+mtlo lo", 64'(bus.lo), 64'hCAFEF00D);

    // MTLO while busy is ignored and stalls.
    bus.go = 1'b1; bus.is_signed = 1'b0; bus.a = 32'h2; bus.b = 32'h3;
    @(negedge clk);
    bus.go = 1'b0;
    @(negedge clk);
    bus.write_lo = 1'b1; bus.wdata = 32'hDEADBEEF;
    #1;
    check("busy mtlo stall", 64'(bus.stall), 64'd1);
    @(negedge clk);
    bus.write_lo = 1'b0;
    check("busy mtlo ignored", 64'(bus.lo), 64'hCAFEF00D);
    repeat (LATENCY) @(negedge clk);
    check("2x3 lo", 64'(bus.lo), 64'h6);
    check("2x3 hi", 64'(bus.hi), 64'h0);

    // Reset in cycle 10 of a -3*5 operation discards it.
    @(negedge clk);
    bus.go = 1'b1; bus.is_signed = 1'b1; bus.a = 32'hFFFFFFFD; bus.b = 32'h5;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy", 64'(bus.busy), 64'd0);
    check("mid reset hi", 64'(bus.hi), 64'd0);
    check("mid reset lo", 64'(bus.lo), 64'd0);
    check("mid reset mul_st", 64'(bus.mul_st), 64'd0);
    check("mid reset mul_a", 64'(bus.mul_a), 64'd0);
    run_op("post-reset 7x6", 1'b0, 32'h7, 32'h6, 32'h7, 32'h6, 32'h0, 32'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
